// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for one pipeline stage register: upstream push side,
// downstream pop side, flush, stall counter and a debug view of the stage state.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 5,
  parameter int CW    = 16
);
  // valid/ready: a transfer happens at a rising edge when both valid and ready are 1;
  // in_ready comes from registered state only, so it never depends on out_ready.
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [CW-1:0]        stall_cnt;
  logic [1:0]           state_dbg;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt, state_dbg
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, stall_cnt, state_dbg
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a 2-entry skid buffer (main slot M, skid slot S),
// synchronous flush, NOP bubble on empty and a saturating stall-cycle counter.
module pipe_stage_buf #(
  parameter int               WIDTH  = 32,
  parameter int               NCH    = 5,
  parameter logic [WIDTH-1:0] NOP_IR = WIDTH'(32'h00000013),
  parameter int               CW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_buf_if.slave  bus
);
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // Lane 0 carries the NOP instruction, every other lane is zero.
  localparam logic [NCH*WIDTH-1:0] BUBBLE = (NCH*WIDTH)'(NOP_IR);

  logic [1:0]           r_state;
  logic [NCH*WIDTH-1:0] r_m;
  logic [NCH*WIDTH-1:0] r_s;
  logic [CW-1:0]        r_stall;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_in_ready  = (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_m     <= BUBBLE;
      r_s     <= BUBBLE;
      r_stall <= '0;
    end else begin
      // Stall accounting is independent of flush; only reset clears it.
      if (w_out_valid && !bus.out_ready && (r_stall != {CW{1'b1}}))
        r_stall <= r_stall + CW'(1);

      if (bus.flush) begin
        r_state <= ST_EMPTY;
        r_m     <= BUBBLE;
        r_s     <= BUBBLE;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_push) begin
              r_m     <= bus.in_data;
              r_state <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_push && w_pop) begin
              r_m <= bus.in_data;
            end else if (w_push) begin
              r_s     <= bus.in_data;
              r_state <= ST_FULL;
            end else if (w_pop) begin
              r_state <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (w_pop) begin
              r_m     <= r_s;
              r_state <= ST_ONE;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  // M keeps its stale contents after the last pop, so the bubble is muxed in here.
  assign bus.out_data  = w_out_valid ? r_m : BUBBLE;
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign bus.stall_cnt = r_stall;
  assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table and corner sequences on a
// 5x32 instance (CW=4), then random handshakes on a 3x8 instance against a queue model.
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_buf_if #(.WIDTH(32), .NCH(5), .CW(4))  ifa();
  pipe_stage_buf_if #(.WIDTH(8),  .NCH(3), .CW(16)) ifb();

  pipe_stage_buf #(.WIDTH(32), .NCH(5), .NOP_IR(32'h00000013), .CW(4)) u_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  pipe_stage_buf #(.WIDTH(8), .NCH(3), .NOP_IR(8'h13), .CW(16)) u_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] d;
    logic        ev;
    logic        er;
    logic [31:0] ed;
    logic [3:0]  es;
  } vec_t;

  vec_t tbl[16];
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] vec_a(input logic valid, input logic [31:0] d);
    logic [159:0] v;
    v = 160'h13;
    if (valid)
      for (int k = 0; k < 5; k++) v[k*32 +: 32] = d + 32'(k) * 32'h1000;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic fl, input logic iv, input logic ordy, input logic [31:0] d);
    ifa.flush     = fl;
    ifa.in_valid  = iv;
    ifa.out_ready = ordy;
    ifa.in_data   = vec_a(1'b1, d);
  endtask

  task automatic do_reset();
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.in_data = '0;
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned scnt;
    logic        iv, ordy, fl, pop, push;
    logic [23:0] d;

    // Stream, back-pressure, flush in FULL, flush with pop, flush with push in EMPTY.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h00500093, 1'b1, 1'b1, 32'h00500093, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h00A00113, 1'b1, 1'b1, 32'h00A00113, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h00F00193, 1'b1, 1'b1, 32'h00F00193, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,        4'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h11,       1'b1, 1'b1, 32'h11,       4'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h22,       1'b1, 1'b0, 32'h11,       4'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11,       4'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h22,       4'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,        4'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h33,       1'b1, 1'b1, 32'h33,       4'd2};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h44,       1'b1, 1'b0, 32'h33,       4'd3};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h55,       1'b0, 1'b1, 32'h0,        4'd4};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,        4'd4};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h66,       1'b1, 1'b1, 32'h66,       4'd4};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,        4'd4};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h77,       1'b0, 1'b1, 32'h0,        4'd4};

    do_reset();
    check("rst_out_valid", 160'(ifa.out_valid), 160'(1'b0));
    check("rst_in_ready",  160'(ifa.in_ready),  160'(1'b1));
    check("rst_out_data",  ifa.out_data,        vec_a(1'b0, 32'h0));
    check("rst_stall",     160'(ifa.stall_cnt), 160'(4'd0));

    for (int i = 0; i < 16; i++) begin
      drive_a(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].d);
      step();
      check($sformatf("vec%0d_out_valid", i), 160'(ifa.out_valid), 160'(tbl[i].ev));
      check($sformatf("vec%0d_in_ready", i),  160'(ifa.in_ready),  160'(tbl[i].er));
      check($sformatf("vec%0d_out_data", i),  ifa.out_data,        vec_a(tbl[i].ev, tbl[i].ed));
      check($sformatf("vec%0d_stall", i),     160'(ifa.stall_cnt), 160'(tbl[i].es));
    end

    // Asynchronous reset while FULL, between clock edges.
    drive_a(1'b0, 1'b1, 1'b0, 32'hA1); step();
    drive_a(1'b0, 1'b1, 1'b0, 32'hA2); step();
    check("pre_rst_in_ready", 160'(ifa.in_ready), 160'(1'b0));
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 160'(ifa.out_valid), 160'(1'b0));
    check("async_rst_in_ready",  160'(ifa.in_ready),  160'(1'b1));
    check("async_rst_out_data",  ifa.out_data,        vec_a(1'b0, 32'h0));
    check("async_rst_stall",     160'(ifa.stall_cnt), 160'(4'd0));
    #2 rst = 1'b0;
    drive_a(1'b0, 1'b1, 1'b1, 32'hB1);
    step();
    check("post_rst_push_valid", 160'(ifa.out_valid), 160'(1'b1));
    check("post_rst_push_data",  ifa.out_data,        vec_a(1'b1, 32'hB1));

    // Stall counter saturation at 2^4-1.
    do_reset();
    drive_a(1'b0, 1'b1, 1'b0, 32'hC1);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    scnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      scnt = (scnt < 15) ? scnt + 1 : 15;
      check($sformatf("sat_stall_%0d", i), 160'(ifa.stall_cnt), 160'(scnt));
    end
    check("sat_data_held", ifa.out_data, vec_a(1'b1, 32'hC1));

    // Random handshakes against a 2-deep queue model.
    do_reset();
    exp_q.delete();
    scnt = 0;
    for (int c = 0; c < 600; c++) begin
      check("rnd_out_valid", 160'(ifb.out_valid), 160'(exp_q.size() > 0));
      check("rnd_in_ready",  160'(ifb.in_ready),  160'(exp_q.size() < 2));
      check("rnd_out_data",  160'(ifb.out_data),  160'((exp_q.size() > 0) ? exp_q[0] : 24'h000013));
      check("rnd_stall",     160'(ifb.stall_cnt), 160'(scnt));
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 55);
      fl   = ($urandom_range(0, 99) < 3);
      d    = 24'($urandom);
      ifb.flush = fl; ifb.in_valid = iv; ifb.out_ready = ordy; ifb.in_data = d;
      pop  = (exp_q.size() > 0) && ordy;
      push = (exp_q.size() < 2) && iv;
      if (exp_q.size() > 0 && !ordy && scnt < 65535) scnt++;
      if (fl) exp_q.delete();
      else begin
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
